// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: states, instruction classes,
// PC source selection and the default handshake timeout.
package multi_cycle_ctrl_pkg;

  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU      = 3'd0,
    CLS_LOAD     = 3'd1,
    CLS_STORE    = 3'd2,
    CLS_BRANCH   = 3'd3,
    CLS_JUMP     = 3'd4,
    CLS_JUMP_REG = 3'd5,
    CLS_MULT     = 3'd6,
    CLS_HALT     = 3'd7
  } cls_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_sel_t;

  function automatic pc_sel_t pc_sel_for(input cls_t c, input logic taken);
    case (c)
      CLS_BRANCH:   return taken ? PC_BRANCH : PC_PLUS4;
      CLS_JUMP:     return PC_JUMP;
      CLS_JUMP_REG: return PC_REG;
      default:      return PC_PLUS4;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_perf_counters.sv
// Retired-instruction and memory-stall counters; only instantiated when PERF_CNT_EN is defined.
module perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic        stall,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
);

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pc_en) instr_cnt <= instr_cnt + 32'd1;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM with memory handshake timeout.
// Optional performance counters are enabled with the PERF_CNT_EN macro.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic [2:0]  cls,
  input  logic        wr_req,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_en,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        rf_we,
  output logic        hilo_we,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        busy,
  output logic        halted,
  output logic        fault,
`ifdef PERF_CNT_EN
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic [2:0]  state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) + 1;

  state_t           state_q, state_d;
  cls_t             cls_e;
  pc_sel_t          sel;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  assign cls_e   = cls_t'(cls);
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Counts cycles spent waiting in FETCH/MEM; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if ((state_d == state_q) && (state_q == ST_FETCH || state_q == ST_MEM))
      wait_cnt <= wait_cnt + CNT_W'(1);
    else
      wait_cnt <= '0;
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_en    = 1'b0;
    dmem_rd  = 1'b0;
    dmem_wr  = 1'b0;
    rf_we    = 1'b0;
    hilo_we  = 1'b0;
    pc_en    = 1'b0;
    sel      = PC_PLUS4;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = (cls_e == CLS_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (cls_e)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_ALU:             state_d = ST_WB;
          default: begin
            if (cls_e == CLS_JUMP && wr_req) begin
              state_d = ST_WB;
            end else begin
              hilo_we = (cls_e == CLS_MULT);
              pc_en   = 1'b1;
              sel     = pc_sel_for(cls_e, br_taken);
              state_d = ST_FETCH;
            end
          end
        endcase
      end
      ST_MEM: begin
        // A store retires directly from MEM; anything else is treated as a load.
        dmem_wr = (cls_e == CLS_STORE);
        dmem_rd = (cls_e != CLS_STORE);
        if (dmem_ack) begin
          if (cls_e == CLS_STORE) begin
            pc_en   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        rf_we   = wr_req;
        pc_en   = 1'b1;
        sel     = pc_sel_for(cls_e, br_taken);
        state_d = ST_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  assign pc_sel = sel;
  assign state  = state_q;
  assign busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                  (state_q == ST_MEM)   || (state_q == ST_WB);
  assign halted = (state_q == ST_HALT);
  assign fault  = (state_q == ST_FAULT);

`ifdef PERF_CNT_EN
  logic stall;
  assign stall = (state_q == ST_FETCH && !imem_ack) || (state_q == ST_MEM && !dmem_ack);

  perf_counters u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_en     (pc_en),
    .stall     (stall),
    .instr_cnt (instr_cnt),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15, giving the maximum wait cycles for a memory handshake before the block raises a fault.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: pulse that begins execution from IDLE.
REQ-005 SHALL have port imem_ack, input, 1 bit: instruction memory returns the word this cycle.
REQ-006 SHALL have port dmem_ack, input, 1 bit: data memory completes the read or write this cycle.
REQ-007 SHALL have port cls, input, 3 bits: decoded class of the current instruction: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 JUMP_REG, 6 MULT, 7 HALT.
REQ-008 SHALL have port wr_req, input, 1 bit: the decoder's reg_write for the current instruction.
REQ-009 SHALL have port br_taken, input, 1 bit: branch condition result, valid in EXEC.
REQ-010 SHALL have outputs imem_req, ir_en, dmem_rd, dmem_wr, rf_we, hilo_we, pc_en, pc_sel[1:0], busy, halted, fault; all are 1 bit except pc_sel, which is 2 bits (0 = PC+4, 1 = branch target, 2 = jump target, 3 = register).
REQ-011 SHALL have output state, 3 bits, exposing the current FSM state.

Function
REQ-012 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
REQ-013 IDLE SHALL go to FETCH on start=1, and stay in IDLE otherwise.
REQ-014 FETCH SHALL assert imem_req every cycle until imem_ack; ir_en SHALL pulse in the ack cycle; the next state SHALL be DECODE.
REQ-015 DECODE SHALL last exactly 1 cycle: HALT class goes to HALT, every other class goes to EXEC.
REQ-016 EXEC SHALL last 1 cycle, with these next states:
- LOAD and STORE go to MEM.
- ALU, and JUMP with wr_req (jal), go to WB.
- MULT asserts hilo_we and goes to FETCH.
- BRANCH, JUMP without wr_req, and JUMP_REG go to FETCH.
REQ-017 pc_en SHALL pulse exactly once per instruction, in the cycle that leaves EXEC/MEM/WB toward FETCH.
REQ-018 pc_sel at that pulse SHALL be:
- 1 when BRANCH and br_taken.
- 2 for JUMP.
- 3 for JUMP_REG.
- 0 otherwise.
REQ-019 MEM SHALL hold dmem_rd (LOAD) or dmem_wr (STORE) until dmem_ack. On ack, LOAD goes to WB and STORE goes to FETCH with pc_en.
REQ-020 WB SHALL last 1 cycle, assert rf_we=wr_req, pulse pc_en, and go to FETCH.
REQ-021 Latencies with zero-wait memory SHALL be: ALU 4 cycles, LOAD 5, STORE 4, BRANCH/JUMP/MULT 3.
REQ-022 A wait counter SHALL clear on entry to FETCH or MEM. If it reaches TIMEOUT_CYC without an ack, the FSM SHALL go to FAULT and assert fault.
REQ-023 An ack arriving in the same cycle the counter hits TIMEOUT_CYC SHALL win; no fault is raised.
REQ-024 HALT and FAULT SHALL be sticky until reset. start SHALL be ignored in every state except IDLE.
REQ-025 busy SHALL be 1 in FETCH through WB; halted SHALL be 1 only in HALT.
REQ-026 At most one of imem_req, dmem_rd, dmem_wr SHALL be high in any cycle.

Reset
REQ-027 rst_n low SHALL immediately force state to IDLE, clear the wait counter, and drive every output to 0, including mid-handshake.
REQ-028 After rst_n deasserts, no request SHALL issue until start is seen.

Configuration
REQ-029 With PERF_CNT_EN defined, the block SHALL add outputs instr_cnt[31:0] and stall_cnt[31:0]:
- instr_cnt increments on each pc_en.
- stall_cnt increments on each FETCH/MEM cycle without an ack.
- Both clear on reset and wrap from 0xFFFFFFFF to 0.
REQ-030 Without PERF_CNT_EN, neither port nor the counter logic SHALL exist, and the remaining behaviour SHALL be identical.

Structure
REQ-031 A shared package SHALL hold the state encoding, the cls encoding, the pc_sel encoding, and the TIMEOUT_CYC default.
REQ-032 The counters SHALL live in one sub-module, perf_counters, instantiated only under PERF_CNT_EN.

Verification
REQ-033 ALU: start, cls=0, wr_req=1, imem_ack in the first FETCH cycle -> rf_we high once in cycle 4, pc_en with pc_sel=0, back in FETCH in cycle 5.
REQ-034 LOAD with dmem_ack delayed 3 cycles -> dmem_rd held 4 cycles, then WB with rf_we=1, total 8 cycles.
REQ-035 BRANCH with br_taken=1 -> pc_sel=1; with br_taken=0 -> pc_sel=0; rf_we never asserted.
REQ-036 Fetch with no imem_ack for TIMEOUT_CYC=15 cycles -> state=7 and fault=1 and sticky; an ack in cycle 15 instead -> DECODE with no fault.
REQ-037 rst_n low while in MEM with dmem_wr=1 -> all outputs 0 immediately, state=0, and no imem_req until start.
REQ-038 With PERF_CNT_EN, 3 ALU instructions plus HALT, each fetch with 1 wait cycle -> instr_cnt=3, stall_cnt=4, halted=1.
